// File: rtl/dmem_access_pkg.sv
// Shared definitions for the data-memory access controller: funct3 codes,
// FSM state encoding and access size/mask helpers.
package dmem_access_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_LO   = 3'd1,
        ST_RD_LAST = 3'd2,
        ST_WR_HI   = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Access size in bytes (1, 2 or 4).
    function automatic logic [2:0] access_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: access_size = 3'd1;
            F3_H, F3_HU: access_size = 3'd2;
            default:     access_size = 3'd4;
        endcase
    endfunction

    // Byte mask (1 << size) - 1, right-justified.
    function automatic logic [3:0] access_mask(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: access_mask = 4'b0001;
            F3_H, F3_HU: access_mask = 4'b0011;
            default:     access_mask = 4'b1111;
        endcase
    endfunction

    // Unsigned loads have no store counterpart; 011/110/111 are never legal.
    function automatic logic f3_legal(input logic [2:0] f3, input logic store);
        case (f3)
            F3_B, F3_H, F3_W: f3_legal = 1'b1;
            F3_BU, F3_HU:     f3_legal = !store;
            default:          f3_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_align.sv
// Load extraction: shifts the {hi,lo} word pair down by the byte offset,
// keeps the access width and sign- or zero-extends to 32 bits.
module mem_load_align
    import dmem_access_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    input  logic [63:0] data,
    output logic [31:0] rdata
);

    logic [31:0] shifted;
    logic [31:0] unused_shift_hi;

    assign {unused_shift_hi, shifted} = data >> {off, 3'b000};

    // Width select and extension by funct3; illegal codes yield zero.
    always_comb begin
        rdata = '0;
        case (funct3)
            F3_B:    rdata = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    rdata = {{16{shifted[15]}}, shifted[15:0]};
            F3_W:    rdata = shifted;
            F3_BU:   rdata = {24'b0, shifted[7:0]};
            F3_HU:   rdata = {16'b0, shifted[15:0]};
            default: rdata = '0;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Memory-stage controller: converts RV32 load/store requests into dmem
// cycles, splitting word-straddling accesses into a lo and a hi cycle.
//
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  ST_IDLE    | ready; first dmem cycle driven straight from req_* on accept
//  ST_RD_LO   | lo word of a split load arrives; latch it, read wa+1
//  ST_RD_LAST | final read word on dmem_dout; extend and respond
//  ST_WR_HI   | write the hi part of a split store to wa+1
//  ST_DONE    | store or illegal-funct3 completion pulse
module dmem_access_ctrl
    import dmem_access_pkg::*;
#(
    parameter int AWIDTH = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              dmem_en,
    output logic [3:0]        dmem_we,
    output logic [AWIDTH-1:0] dmem_addr,
    output logic [31:0]       dmem_din,
    input  logic [31:0]       dmem_dout
);

    state_t state, state_nxt;

    logic [2:0]        r_funct3;
    logic [1:0]        r_off;
    logic [AWIDTH-1:0] r_wa;
    logic [31:0]       r_wdata;
    logic              r_split;
    logic              r_err;
    logic [31:0]       lo_buf;

    logic              en_i;
    logic [3:0]        we_i;
    logic              rsp_valid_i;
    logic              rsp_err_i;

    // Request decode, only meaningful in ST_IDLE.
    logic [1:0]        req_off;
    logic [AWIDTH-1:0] req_wa;
    logic [2:0]        req_n;
    logic [7:0]        req_mask8;
    logic              req_split;
    logic              req_legal;
    logic              accept;
    logic              unused_addr_hi;

    assign req_off        = req_addr[1:0];
    assign req_wa         = req_addr[AWIDTH+1:2];
    assign req_n          = access_size(req_funct3);
    assign req_mask8      = {4'b0, access_mask(req_funct3)} << req_off;
    assign req_split      = ({1'b0, req_off} + req_n) > 3'd4;
    assign req_legal      = f3_legal(req_funct3, req_store);
    assign accept         = req_valid && (state == ST_IDLE);
    assign unused_addr_hi = ^req_addr[31:AWIDTH+2];

    // Hi-cycle values from the registered request; wa+1 wraps at the top.
    logic [AWIDTH-1:0] r_wa_inc;
    logic [7:0]        r_mask8;
    logic [5:0]        hi_sh;
    logic [31:0]       hi_din;

    assign r_wa_inc = r_wa + AWIDTH'(1);
    assign r_mask8  = {4'b0, access_mask(r_funct3)} << r_off;
    assign hi_sh    = 6'd32 - {1'b0, r_off, 3'b000};
    assign hi_din   = r_wdata >> hi_sh;

    logic [63:0] align_data;
    logic [31:0] load_data;

    assign align_data = r_split ? {dmem_dout, lo_buf} : {32'b0, dmem_dout};

    mem_load_align u_align (
        .off    (r_off),
        .funct3 (r_funct3),
        .data   (align_data),
        .rdata  (load_data)
    );

    // State register, request capture on accept and lo-word buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            r_funct3 <= '0;
            r_off    <= '0;
            r_wa     <= '0;
            r_wdata  <= '0;
            r_split  <= 1'b0;
            r_err    <= 1'b0;
            lo_buf   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                r_funct3 <= req_funct3;
                r_off    <= req_off;
                r_wa     <= req_wa;
                r_wdata  <= req_wdata;
                r_split  <= req_split && req_legal;
                r_err    <= !req_legal;
            end
            if (state == ST_RD_LO) begin
                lo_buf <= dmem_dout;
            end
        end
    end

    // Next-state, dmem cycle and response generation.
    always_comb begin
        state_nxt   = state;
        en_i        = 1'b0;
        we_i        = 4'b0000;
        dmem_addr   = '0;
        dmem_din    = '0;
        rsp_valid_i = 1'b0;
        rsp_err_i   = 1'b0;
        rsp_rdata   = '0;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (!req_legal) begin
                        state_nxt = ST_DONE;
                    end else begin
                        en_i      = 1'b1;
                        dmem_addr = req_wa;
                        dmem_din  = req_wdata << {req_off, 3'b000};
                        if (req_store) begin
                            we_i      = req_mask8[3:0];
                            state_nxt = req_split ? ST_WR_HI : ST_DONE;
                        end else begin
                            state_nxt = req_split ? ST_RD_LO : ST_RD_LAST;
                        end
                    end
                end
            end
            ST_RD_LO: begin
                en_i      = 1'b1;
                dmem_addr = r_wa_inc;
                state_nxt = ST_RD_LAST;
            end
            ST_RD_LAST: begin
                rsp_valid_i = 1'b1;
                rsp_rdata   = load_data;
                state_nxt   = ST_IDLE;
            end
            ST_WR_HI: begin
                en_i      = 1'b1;
                dmem_addr = r_wa_inc;
                we_i      = r_mask8[7:4];
                dmem_din  = hi_din;
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                rsp_valid_i = 1'b1;
                rsp_err_i   = r_err;
                state_nxt   = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Reset held mid-operation must not let a pending hi write or response escape.
    assign req_ready = (state == ST_IDLE);
    assign dmem_en   = en_i && !rst;
    assign dmem_we   = rst ? 4'b0000 : we_i;
    assign rsp_valid = rsp_valid_i && !rst;
    assign rsp_err   = rsp_err_i && !rst;

endmodule
